// File: rtl/qspi_fast_read_slave_pkg.sv
// Shared opcode, address width, dummy-cycle default and FSM encoding for the QSPI fast-read target.
package qspi_fast_read_slave_pkg;

   localparam logic [7:0] CMD_FAST_READ = 8'h0b;
   localparam int         ADDR_BITS     = 24;
   localparam int         DUMMY_CYC     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA
   } state_t;

endpackage

// File: rtl/qspi_fast_read_slave_rd_buf.sv
// RD_BL-word read buffer: in-order writes, per-word valid bits, byte read port with same-cycle write bypass.
// Writes land one edge after rd_data_vld; words beyond RD_BL are dropped (no backpressure).
module qspi_rd_buf #(
   parameter int RD_BL = 2
) (
   input  logic        qspi_clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        wr,
   input  logic [15:0] wr_data,
   input  logic [7:0]  byte_sel,
   output logic [7:0]  rd_byte,
   output logic        rd_ok
);

   localparam logic [7:0] DEPTH = 8'(RD_BL);

   logic [15:0]      mem [RD_BL];
   logic [RD_BL-1:0] valid;
   logic [7:0]       wptr;
   logic             wr_hit;
   logic [15:0]      word;

   assign wr_hit = wr && (wptr < DEPTH);

   always_ff @(posedge qspi_clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= 8'd0;
         valid <= '0;
         for (int i = 0; i < RD_BL; i++) mem[i] <= 16'h0000;
      end else if (clr) begin
         wptr  <= 8'd0;
         valid <= '0;
      end else if (wr_hit) begin
         wptr <= wptr + 8'd1;
         for (int i = 0; i < RD_BL; i++) begin
            if (wptr == 8'(i)) begin
               mem[i]   <= wr_data;
               valid[i] <= 1'b1;
            end
         end
      end
   end

   // A word arriving on the very edge its byte is needed is forwarded straight through.
   always_comb begin
      word  = 16'h0000;
      rd_ok = 1'b0;
      for (int i = 0; i < RD_BL; i++) begin
         if (byte_sel[7:1] == 7'(i)) begin
            if (valid[i]) begin
               word  = mem[i];
               rd_ok = 1'b1;
            end else if (wr_hit && (wptr == 8'(i))) begin
               word  = wr_data;
               rd_ok = 1'b1;
            end
         end
      end
      rd_byte = byte_sel[0] ? word[7:0] : word[15:8];
   end

endmodule

// File: rtl/qspi_fast_read_slave.sv
// Single-lane QSPI fast-read (0x0B) target: opcode hunt, 24-bit address, dummy cycles, 2*RD_BL bytes out MSB-first.
// First data bit appears on the last dummy edge; a late SDRAM word yields 0x00 bytes and a sticky underrun flag.
module qspi_fast_read_slave #(
   parameter int         RD_BL         = 2,
   parameter logic [7:0] CMD_FAST_READ = qspi_fast_read_slave_pkg::CMD_FAST_READ,
   parameter int         DUMMY_CYC     = qspi_fast_read_slave_pkg::DUMMY_CYC
) (
   input  logic        qspi_clk,
   input  logic        rst_n,
   input  logic        csn,
   input  logic        di,
   output logic        dout,
   output logic        rd_req,
   output logic [23:0] rd_addr,
   input  logic        rd_ack,
   input  logic [15:0] rd_data,
   input  logic        rd_data_vld,
   output logic        busy,
   output logic        underrun_err,
   output logic [7:0]  xfer_cnt
);
   import qspi_fast_read_slave_pkg::*;

   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);
   localparam logic [7:0] DATA_LAST  = 8'(16 * RD_BL - 1);

   state_t               state;
   logic [7:0]           win;
   logic [7:0]           win_nxt;
   logic [7:0]           cnt;
   logic [7:0]           load_idx;
   logic [ADDR_BITS-2:0] addr_sh;
   logic [6:0]           data_sh;
   logic                 buf_clr;
   logic                 buf_wr;
   logic                 buf_ok;
   logic [7:0]           buf_byte;

   assign win_nxt  = {win[6:0], di};
   // Index of the data bit driven on this edge; multiples of 8 fetch a fresh byte.
   assign load_idx = (state == ST_DATA) ? cnt + 8'd1 : 8'd0;
   assign buf_clr  = !csn && (state == ST_ADDR) && (cnt == ADDR_LAST);
   assign buf_wr   = rd_data_vld && ((state == ST_DUMMY) || (state == ST_DATA));
   assign busy     = (state != ST_IDLE);

   qspi_rd_buf #(
      .RD_BL (RD_BL)
   ) u_rd_buf (
      .qspi_clk (qspi_clk),
      .rst_n    (rst_n),
      .clr      (buf_clr),
      .wr       (buf_wr),
      .wr_data  (rd_data),
      .byte_sel (load_idx >> 3),
      .rd_byte  (buf_byte),
      .rd_ok    (buf_ok)
   );

   always_ff @(posedge qspi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         win          <= 8'h00;
         cnt          <= 8'd0;
         addr_sh      <= '0;
         data_sh      <= 7'h00;
         dout         <= 1'b0;
         rd_req       <= 1'b0;
         rd_addr      <= 24'h000000;
         underrun_err <= 1'b0;
         xfer_cnt     <= 8'd0;
      end else begin
         if (rd_ack) rd_req <= 1'b0;
         if (csn) begin
            state  <= ST_IDLE;
            win    <= 8'h00;
            cnt    <= 8'd0;
            rd_req <= 1'b0;
            dout   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  win <= win_nxt;
                  if (win_nxt == CMD_FAST_READ) begin
                     state <= ST_ADDR;
                     cnt   <= 8'd0;
                  end
               end
               ST_ADDR: begin
                  addr_sh <= {addr_sh[ADDR_BITS-3:0], di};
                  cnt     <= cnt + 8'd1;
                  if (cnt == ADDR_LAST) begin
                     rd_addr <= {addr_sh, di};
                     rd_req  <= 1'b1;
                     state   <= ST_DUMMY;
                     cnt     <= 8'd0;
                  end
               end
               ST_DUMMY: begin
                  cnt <= cnt + 8'd1;
                  if (cnt == DUMMY_LAST) begin
                     dout    <= buf_ok & buf_byte[7];
                     data_sh <= buf_ok ? buf_byte[6:0] : 7'h00;
                     if (!buf_ok) underrun_err <= 1'b1;
                     state   <= ST_DATA;
                     cnt     <= 8'd0;
                  end
               end
               ST_DATA: begin
                  if (cnt == DATA_LAST) begin
                     state    <= ST_IDLE;
                     win      <= 8'h00;
                     cnt      <= 8'd0;
                     dout     <= 1'b0;
                     rd_req   <= 1'b0;
                     xfer_cnt <= xfer_cnt + 8'd1;
                  end else begin
                     cnt <= load_idx;
                     if (load_idx[2:0] == 3'd0) begin
                        dout    <= buf_ok & buf_byte[7];
                        data_sh <= buf_ok ? buf_byte[6:0] : 7'h00;
                        if (!buf_ok) underrun_err <= 1'b1;
                     end else begin
                        dout    <= data_sh[6];
                        data_sh <= {data_sh[5:0], 1'b0};
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qspi_fast_read_slave.sv
// Bench for qspi_fast_read_slave: directed scenarios plus random transactions against a cycle-timeline reference model.
module tb_qspi_fast_read_slave;

   localparam int RD_BL  = 2;
   localparam int NB     = 2 * RD_BL;
   localparam int NBIT   = 16 * RD_BL;
   localparam int T_ADDR = 31;            // edge sampling the last address bit
   localparam int T_WIN  = 32;            // first edge a word may be written
   localparam int T_LOAD = 39;            // edge driving data bit 0
   localparam int T_END  = T_LOAD + NBIT; // edge returning to idle
   localparam int NEVER  = 1000;

   logic        qspi_clk = 1'b0;
   logic        rst_n;
   logic        csn;
   logic        di;
   logic        dout;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_ack;
   logic [15:0] rd_data;
   logic        rd_data_vld;
   logic        busy;
   logic        underrun_err;
   logic [7:0]  xfer_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  m_cnt = 8'd0;
   logic        m_err = 1'b0;

   always #5 qspi_clk = ~qspi_clk;

   qspi_fast_read_slave #(.RD_BL(RD_BL)) dut (
      .qspi_clk     (qspi_clk),
      .rst_n        (rst_n),
      .csn          (csn),
      .di           (di),
      .dout         (dout),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_ack       (rd_ack),
      .rd_data      (rd_data),
      .rd_data_vld  (rd_data_vld),
      .busy         (busy),
      .underrun_err (underrun_err),
      .xfer_cnt     (xfer_cnt)
   );

   task automatic tick();
      @(posedge qspi_clk);
      #1;
   endtask

   task automatic idle(input int n);
      di = 1'b0; rd_ack = 1'b0; rd_data_vld = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         vectors++;
         if (busy !== 1'b0 || dout !== 1'b0) begin
            miscompares++;
            $display("FAIL idle busy/dout: got %b/%b expected 0/0", busy, dout);
         end
      end
   endtask

   // abort_kind: 0 none, 1 csn raised at abort_t, 2 rst_n pulsed after edge abort_t
   task automatic run_xfer(input logic [23:0] addr, input logic [15:0] w0, input logic [15:0] w1,
                           input int tw0, input int tw1, input int ack_d,
                           input int abort_t, input int abort_kind);
      logic [7:0]  cmd;
      logic [15:0] w [RD_BL];
      int          tw [RD_BL];
      logic [7:0]  exp_b [NB];
      logic        under;
      logic        exp_bit;
      logic        exp_req;
      int          m;
      cmd = 8'h0b;
      w[0] = w0; w[1] = w1; tw[0] = tw0; tw[1] = tw1;
      under = 1'b0;
      for (int j = 0; j < NB; j++) begin
         if (tw[j/2] >= T_WIN && tw[j/2] <= T_LOAD + 8*j)
            exp_b[j] = (j % 2 == 0) ? w[j/2][15:8] : w[j/2][7:0];
         else begin
            exp_b[j] = 8'h00;
            under = 1'b1;
         end
      end
      for (int t = 0; t <= T_END; t++) begin
         if (t < 8)        di = cmd[7-t];
         else if (t < 32)  di = addr[23-(t-8)];
         else              di = 1'($urandom);
         rd_ack = (ack_d > 0 && t == T_ADDR + ack_d);
         rd_data_vld = 1'b0;
         rd_data = 16'($urandom);
         for (int k = 0; k < RD_BL; k++) begin
            if (t == tw[k]) begin
               rd_data_vld = 1'b1;
               rd_data = w[k];
            end
         end
         if (abort_kind == 1 && t == abort_t) csn = 1'b1;
         if (abort_kind == 2 && t == abort_t) begin
            @(posedge qspi_clk);
            #2 rst_n = 1'b0;
            #1;
            vectors++;
            if (dout !== 1'b0 || rd_req !== 1'b0 || busy !== 1'b0 || xfer_cnt !== 8'd0 || underrun_err !== 1'b0) begin
               miscompares++;
               $display("FAIL async reset: dout=%b rd_req=%b busy=%b xfer_cnt=%0d err=%b expected all 0",
                        dout, rd_req, busy, xfer_cnt, underrun_err);
            end
            @(negedge qspi_clk);
            rst_n = 1'b1;
            m_cnt = 8'd0;
            m_err = 1'b0;
            return;
         end
         tick();
         if (abort_kind == 1 && t == abort_t) begin
            vectors++;
            if (busy !== 1'b0 || rd_req !== 1'b0 || dout !== 1'b0 || xfer_cnt !== m_cnt) begin
               miscompares++;
               $display("FAIL csn abort: busy=%b rd_req=%b dout=%b xfer_cnt=%0d expected 0/0/0/%0d",
                        busy, rd_req, dout, xfer_cnt, m_cnt);
            end
            csn = 1'b0;
            return;
         end
         if (t < T_ADDR) begin
            vectors++;
            if (rd_req !== 1'b0) begin
               miscompares++;
               $display("FAIL early rd_req t=%0d: got %b expected 0", t, rd_req);
            end
         end else if (t == T_ADDR) begin
            vectors++;
            if (rd_req !== 1'b1 || rd_addr !== addr || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL request: rd_req=%b rd_addr=%h busy=%b expected 1/%h/1", rd_req, rd_addr, busy, addr);
            end
         end else if (t < T_END) begin
            exp_req = (ack_d == 0) || (t < T_ADDR + ack_d);
            vectors++;
            if (rd_req !== exp_req) begin
               miscompares++;
               $display("FAIL rd_req hold t=%0d: got %b expected %b", t, rd_req, exp_req);
            end
         end
         if (t >= T_LOAD && t < T_END) begin
            m = t - T_LOAD;
            exp_bit = exp_b[m/8][7-(m%8)];
            vectors++;
            if (dout !== exp_bit) begin
               miscompares++;
               $display("FAIL data bit %0d (byte %0d=%h): got %b expected %b", m, m/8, exp_b[m/8], dout, exp_bit);
            end
         end
      end
      m_cnt = m_cnt + 8'd1;
      m_err = m_err | under;
      vectors++;
      if (dout !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0 || xfer_cnt !== m_cnt || underrun_err !== m_err) begin
         miscompares++;
         $display("FAIL end of xfer: dout=%b busy=%b rd_req=%b xfer_cnt=%0d err=%b expected 0/0/0/%0d/%b",
                  dout, busy, rd_req, xfer_cnt, underrun_err, m_cnt, m_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; csn = 1'b1; di = 1'b0; rd_ack = 1'b0; rd_data = 16'h0; rd_data_vld = 1'b0;
      #12;
      vectors++;
      if (dout !== 1'b0 || rd_req !== 1'b0 || rd_addr !== 24'h0 || busy !== 1'b0 ||
          underrun_err !== 1'b0 || xfer_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL reset values: dout=%b rd_req=%b rd_addr=%h busy=%b err=%b xfer_cnt=%0d expected all 0",
                  dout, rd_req, rd_addr, busy, underrun_err, xfer_cnt);
      end
      @(negedge qspi_clk);
      rst_n = 1'b1;
      csn = 1'b0;
      idle(10);
   endtask

   task automatic test_basic();
      run_xfer(24'h000000, 16'h1234, 16'h5678, 33, 36, 2, 0, 0);
      idle(4);
      run_xfer(24'h000004, 16'ha5a5, 16'h0f0f, 34, 38, 1, 0, 0);
      idle(4);
   endtask

   task automatic test_underrun();
      run_xfer(24'(($urandom)), 16'hbeef, 16'hcafe, 34, T_LOAD + 26, 3, 0, 0);
      idle(3);
      run_xfer(24'h000010, 16'h1357, 16'h2468, 33, 35, 2, 0, 0);
      idle(8);
   endtask

   task automatic test_bad_opcode();
      logic [7:0] cmd;
      logic [7:0] win;
      logic       b;
      cmd = 8'h03;
      win = 8'h00;
      rd_ack = 1'b0; rd_data_vld = 1'b0;
      for (int t = 0; t < 48; t++) begin
         b = (t < 8) ? cmd[7-t] : 1'($urandom);
         if ({win[6:0], b} == 8'h0b) b = 1'b0;
         win = {win[6:0], b};
         di = b;
         tick();
         vectors++;
         if (busy !== 1'b0 || rd_req !== 1'b0 || dout !== 1'b0) begin
            miscompares++;
            $display("FAIL bad opcode t=%0d: busy=%b rd_req=%b dout=%b expected 0/0/0", t, busy, rd_req, dout);
         end
      end
      idle(8);
   endtask

   task automatic test_csn_abort();
      run_xfer(24'habcdef, 16'h1111, 16'h2222, 33, 34, 2, 18, 1);
      idle(8);
      run_xfer(24'h123456, 16'h9abc, 16'hdef0, 32, 37, 4, 0, 0);
      idle(4);
   endtask

   task automatic test_reset_mid();
      run_xfer(24'h00aa55, 16'h4242, 16'h2424, 33, 35, 2, 50, 2);
      idle(8);
      run_xfer(24'h0055aa, 16'h7e81, 16'h18e7, 34, 36, 2, 0, 0);
      idle(4);
   endtask

   task automatic test_back_to_back();
      int tw0;
      int tw1;
      int ack_d;
      for (int n = 0; n < 10; n++) begin
         tw0 = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(T_WIN, 60));
         tw1 = (tw0 == NEVER || $urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(tw0 + 1, 70));
         ack_d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
         run_xfer(24'($urandom), 16'($urandom), 16'($urandom), tw0, tw1, ack_d, 0, 0);
         idle($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_bad_opcode();
      test_csn_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
